// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default framing parameters.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} uart_rx_state_t;

  localparam int UART_DATA_BITS          = 8;
  localparam int UART_OVERSAMPLE_DEFAULT = 16;
endpackage

// File: rtl/uart_rx_if.sv
// Core-side byte handshake of the UART receiver plus its error pulses.
interface uart_rx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_valid;
  logic                      rx_ready;
  logic                      frame_err;
  logic                      overrun;

  modport master (output rx_data, rx_valid, frame_err, overrun, input rx_ready);
  modport slave  (input rx_data, rx_valid, frame_err, overrun, output rx_ready);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta, r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling on oversample ticks, single-entry
// valid/ready holding register, pulsed framing-error and overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        os_clk,
  input  logic        rx,
  uart_rx_if.master   bus
);
  localparam int TW   = $clog2(OVERSAMPLE);
  localparam int HALF = OVERSAMPLE / 2;
  localparam int DW   = UART_DATA_BITS;

  localparam logic [TW-1:0] C_HALF = TW'(HALF - 1);
  localparam logic [TW-1:0] C_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]    C_BMAX = 3'(DW - 1);

  localparam logic [2:0] S_IDLE    = 3'(IDLE);
  localparam logic [2:0] S_START   = 3'(START);
  localparam logic [2:0] S_DATA    = 3'(DATA);
  localparam logic [2:0] S_STOP    = 3'(STOP);
  localparam logic [2:0] S_WAIT_HI = 3'(WAIT_HI);

  logic          w_rx_s, w_tick, w_stop_smp;
  logic          r_os_q;
  logic [2:0]    r_state;
  logic [TW-1:0] r_tcnt;
  logic [2:0]    r_bidx;
  logic [DW-1:0] r_shift;
  logic [DW-1:0] r_data;
  logic          r_valid, r_ferr, r_ovr;

  sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (rx),
    .o_q     (w_rx_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_os_q <= 1'b0;
    else          r_os_q <= os_clk;
  end

  assign w_tick     = os_clk & ~r_os_q;
  assign w_stop_smp = w_tick && (r_state == S_STOP) && (r_tcnt == C_LAST);

  // Compares use the pre-increment count, so the check lands on the Nth tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_tcnt  <= '0;
      r_bidx  <= '0;
      r_shift <= '0;
    end else if (w_tick) begin
      case (r_state)
        S_IDLE: if (!w_rx_s) begin
          r_tcnt  <= '0;
          r_state <= S_START;
        end
        S_START: begin
          r_tcnt <= r_tcnt + 1'b1;
          if (r_tcnt == C_HALF) begin
            if (w_rx_s) r_state <= S_IDLE;
            else begin
              r_tcnt  <= '0;
              r_bidx  <= '0;
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          r_tcnt <= r_tcnt + 1'b1;
          if (r_tcnt == C_LAST) begin
            r_shift <= {w_rx_s, r_shift[DW-1:1]};
            r_tcnt  <= '0;
            r_bidx  <= r_bidx + 3'd1;
            if (r_bidx == C_BMAX) r_state <= S_STOP;
          end
        end
        S_STOP: begin
          r_tcnt <= r_tcnt + 1'b1;
          if (r_tcnt == C_LAST) begin
            r_tcnt  <= '0;
            r_state <= w_rx_s ? S_IDLE : S_WAIT_HI;
          end
        end
        S_WAIT_HI: if (w_rx_s) r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  // Holding register: a same-cycle consume frees the slot for the new byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_stop_smp & ~w_rx_s;
      r_ovr  <= 1'b0;
      if (r_valid && bus.rx_ready) r_valid <= 1'b0;
      if (w_stop_smp && w_rx_s) begin
        if (!r_valid || bus.rx_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end
    end
  end

  assign bus.rx_data   = r_data;
  assign bus.rx_valid  = r_valid;
  assign bus.frame_err = r_ferr;
  assign bus.overrun   = r_ovr;
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven at bit-time resolution and a
// queue-based model predicts delivered bytes, framing errors and overruns.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int OS     = 16;
  localparam int OS_PER = 26;
  localparam int BIT    = OS * OS_PER;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic os_clk  = 1'b0;
  logic rx      = 1'b1;

  uart_rx_if bus_if ();

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .os_clk  (os_clk),
    .rx      (rx),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  initial forever begin
    repeat (OS_PER / 2) @(negedge clk);
    os_clk = ~os_clk;
  end

  int         n_chk = 0, n_fail = 0;
  logic [7:0] exp_q[$];
  int         exp_ferr = 0, exp_ovr = 0, got_ferr = 0, got_ovr = 0;
  bit         model_full = 1'b0;
  logic       prev_ferr = 1'b0, prev_ovr = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Model: a good frame is delivered unless the holder is full and not being read.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) exp_ferr++;
    else if (model_full && !bus_if.rx_ready) exp_ovr++;
    else begin
      exp_q.push_back(b);
      if (!bus_if.rx_ready) model_full = 1'b1;
    end
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop_ok;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rx_data"},   bus_if.rx_data,   0);
    chk({tag, "_rx_valid"},  bus_if.rx_valid,  0);
    chk({tag, "_frame_err"}, bus_if.frame_err, 0);
    chk({tag, "_overrun"},   bus_if.overrun,   0);
  endtask

  // Monitor: samples just after the negedge drives, i.e. what the next posedge sees.
  initial forever begin
    @(negedge clk);
    #1;
    if (reset_n) begin
      if (bus_if.rx_valid && bus_if.rx_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%0h expected no byte", bus_if.rx_data);
        end else begin
          chk("rx_data", bus_if.rx_data, exp_q.pop_front());
        end
      end
      if (bus_if.frame_err) begin
        got_ferr++;
        chk("frame_err_width", prev_ferr, 0);
      end
      if (bus_if.overrun) begin
        got_ovr++;
        chk("overrun_width", prev_ovr, 0);
      end
    end
    prev_ferr = bus_if.frame_err;
    prev_ovr  = bus_if.overrun;
  end

  initial begin
    logic [7:0] b;
    bus_if.rx_ready = 1'b1;

    repeat (3) @(negedge clk);
    #1 chk_reset_vals("por");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (50) @(negedge clk);

    send_frame(8'h55, 1'b1);
    repeat (100) @(negedge clk);
    chk("single_drained", exp_q.size(), 0);

    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    repeat (100) @(negedge clk);
    chk("b2b_drained", exp_q.size(), 0);

    rx = 1'b0;
    repeat (4 * OS_PER) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    #1;
    chk("glitch_valid", bus_if.rx_valid, 0);
    chk("glitch_ferr", got_ferr, 0);

    send_frame(8'h81, 1'b0);
    repeat (20 * BIT) @(negedge clk);
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
    send_frame(8'h3C, 1'b1);
    repeat (100) @(negedge clk);
    chk("ferr_count", got_ferr, exp_ferr);
    chk("ferr_drained", exp_q.size(), 0);

    bus_if.rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (100) @(negedge clk);
    #1;
    chk("ovr_valid_held", bus_if.rx_valid, 1);
    chk("ovr_data_held", bus_if.rx_data, 8'h11);
    chk("ovr_count", got_ovr, exp_ovr);
    @(negedge clk);
    bus_if.rx_ready = 1'b1;
    @(negedge clk);
    bus_if.rx_ready = 1'b0;
    model_full = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("ovr_valid_cleared", bus_if.rx_valid, 0);
    @(negedge clk);
    bus_if.rx_ready = 1'b1;

    b = 8'hF0;
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = b[4];
    repeat (BIT / 2) @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk_reset_vals("midframe");
    @(negedge clk);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (BIT) @(negedge clk);
    send_frame(8'h0F, 1'b1);
    repeat (100) @(negedge clk);
    chk("reset_drained", exp_q.size(), 0);

    for (int k = 0; k < 3; k++) begin
      send_frame(8'($urandom), 1'b1);
      repeat ($urandom_range(0, 300)) @(negedge clk);
    end
    repeat (200) @(negedge clk);

    chk("final_drained", exp_q.size(), 0);
    chk("final_ferr", got_ferr, exp_ferr);
    chk("final_ovr", got_ovr, exp_ovr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
